// File: rtl/cpu_stage_sequencer_pkg.sv
// Shared TinyCPU architecture constants: stage encodings and instruction types.
// Replaces the old fixed NUM_STAGES / stage-number defines.
package cpu_stage_sequencer_pkg;

  localparam int STAGE_W = 3;
  localparam int TYPE_W  = 5;

  typedef logic [STAGE_W-1:0] stage_t;

  localparam logic [STAGE_W-1:0] STAGE_FETCH     = 3'd0;
  localparam logic [STAGE_W-1:0] STAGE_DECODE    = 3'd1;
  localparam logic [STAGE_W-1:0] STAGE_EXECUTE   = 3'd2;
  localparam logic [STAGE_W-1:0] STAGE_MEMORY    = 3'd3;
  localparam logic [STAGE_W-1:0] STAGE_PC_UPDATE = 3'd4;
  localparam logic [STAGE_W-1:0] STAGE_HALT      = 3'd5;

  localparam logic [TYPE_W-1:0] TYPE_ALU    = 5'd0;
  localparam logic [TYPE_W-1:0] TYPE_LOAD   = 5'd1;
  localparam logic [TYPE_W-1:0] TYPE_STORE  = 5'd2;
  localparam logic [TYPE_W-1:0] TYPE_BRANCH = 5'd3;
  localparam logic [TYPE_W-1:0] TYPE_HALT   = 5'd31;

  localparam logic [TYPE_W-1:0] HALT_TYPE = TYPE_HALT;

endpackage

// File: rtl/cpu_stage_sequencer_mem_wait_watchdog.sv
// Counts consecutive unanswered memory-request cycles and flags a sticky fault
// when MAX_WAIT of them elapse. MAX_WAIT=0 removes the watchdog entirely.
module cpu_stage_sequencer_mem_wait_watchdog #(
  parameter int MAX_WAIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  input  logic mem_ready,
  output logic expire,
  output logic fault
);

  generate
    if (MAX_WAIT > 0) begin : g_wd
      localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

      logic [WW-1:0] wait_cnt_reg;
      logic          fault_reg;

      // Expires on the MAX_WAIT-th request cycle only if ready is still low.
      assign expire = mem_req && !mem_ready && (wait_cnt_reg == WW'(MAX_WAIT - 1));
      assign fault  = fault_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wait_cnt_reg <= '0;
          fault_reg    <= 1'b0;
        end else begin
          if (!mem_req || mem_ready || expire)
            wait_cnt_reg <= '0;
          else
            wait_cnt_reg <= wait_cnt_reg + WW'(1);
          if (expire)
            fault_reg <= 1'b1;
        end
      end
    end else begin : g_no_wd
      assign expire = 1'b0;
      assign fault  = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/cpu_stage_sequencer.sv
// TinyCPU multi-cycle stage controller: FETCH/DECODE/EXECUTE/MEMORY/PC_UPDATE
// with a variable-latency memory handshake, optional MEMORY skip and halt.
module cpu_stage_sequencer #(
  parameter int               STAGE_W   = cpu_stage_sequencer_pkg::STAGE_W,
  parameter int               TYPE_W    = cpu_stage_sequencer_pkg::TYPE_W,
  parameter logic [TYPE_W-1:0] HALT_TYPE = TYPE_W'(cpu_stage_sequencer_pkg::HALT_TYPE),
  parameter bit               SKIP_MEM  = 1'b0,
  parameter int               CNT_W     = 32,
  parameter int               MAX_WAIT  = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_en,
  input  logic [TYPE_W-1:0]  instr_type,
  input  logic               instr_is_mem,
  input  logic               mem_ready,
  output logic [STAGE_W-1:0] stage,
  output logic               mem_req,
  output logic               mem_is_fetch,
  output logic               issue_en,
  output logic               exec_en,
  output logic               pc_update_en,
  output logic               retire,
  output logic               halted,
  output logic               fault,
  output logic [CNT_W-1:0]   instret,
  output logic [CNT_W-1:0]   stall_cycles
);

  import cpu_stage_sequencer_pkg::*;

  stage_t           state_reg, state_next;
  logic             fetch_hold_reg;
  logic [CNT_W-1:0] instret_reg;
  logic [CNT_W-1:0] stall_reg;
  logic             in_fetch, in_mem, handshake, wd_expire, wd_fault;

  assign in_fetch = (state_reg == STAGE_FETCH);
  assign in_mem   = (state_reg == STAGE_MEMORY);

  // A fetch that has started keeps requesting until answered, even if run_en drops.
  // Gating with rst keeps the request low while reset is held.
  assign mem_req   = rst && ((in_fetch && (run_en || fetch_hold_reg)) || (in_mem && instr_is_mem));
  assign handshake = mem_req && mem_ready;

  assign stage        = STAGE_W'(state_reg);
  assign mem_is_fetch = in_fetch && mem_req;
  assign issue_en     = in_fetch && handshake;
  assign exec_en      = (state_reg == STAGE_EXECUTE);
  assign pc_update_en = (state_reg == STAGE_PC_UPDATE);
  assign retire       = (state_reg == STAGE_PC_UPDATE);
  assign halted       = (state_reg == STAGE_HALT);
  assign fault        = wd_fault;
  assign instret      = instret_reg;
  assign stall_cycles = stall_reg;

  cpu_stage_sequencer_mem_wait_watchdog #(
    .MAX_WAIT(MAX_WAIT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req),
    .mem_ready(mem_ready),
    .expire   (wd_expire),
    .fault    (wd_fault)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      STAGE_FETCH: begin
        if (wd_expire)      state_next = STAGE_HALT;
        else if (handshake) state_next = STAGE_DECODE;
      end
      STAGE_DECODE:
        state_next = (instr_type == HALT_TYPE) ? STAGE_HALT : STAGE_EXECUTE;
      STAGE_EXECUTE:
        state_next = (SKIP_MEM && !instr_is_mem) ? STAGE_PC_UPDATE : STAGE_MEMORY;
      STAGE_MEMORY: begin
        if (wd_expire)                      state_next = STAGE_HALT;
        else if (!instr_is_mem || handshake) state_next = STAGE_PC_UPDATE;
      end
      STAGE_PC_UPDATE: state_next = STAGE_FETCH;
      STAGE_HALT:      state_next = STAGE_HALT;
      // Unused encodings trap rather than run with undefined enables.
      default:         state_next = STAGE_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= STAGE_FETCH;
      fetch_hold_reg <= 1'b0;
      instret_reg    <= '0;
      stall_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      fetch_hold_reg <= in_fetch && mem_req && !mem_ready;
      if (state_reg == STAGE_PC_UPDATE)
        instret_reg <= instret_reg + CNT_W'(1);
      if (mem_req && !mem_ready && (stall_reg != '1))
        stall_reg <= stall_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Scoreboard bench: two sequencers (SKIP_MEM=0 and SKIP_MEM=1, MAX_WAIT=4)
// driven by directed instruction streams and a latency-programmable memory.
module tb_cpu_stage_sequencer;

  localparam logic [2:0] ST_FETCH = 3'd0, ST_MEMORY = 3'd3, ST_HALT = 3'd5;
  localparam logic [4:0] T_ALU = 5'd0, T_LOAD = 5'd1, T_STORE = 5'd2, T_HALT = 5'd31;
  localparam logic [1:0] EV_ISSUE = 2'd0, EV_RETIRE = 2'd1, EV_HALT = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] cyc;
    logic [31:0] aux;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, sel, run_en, instr_is_mem, mem_ready;
  logic [4:0] instr_type;

  logic [2:0]  stage_a, stage_b;
  logic        mem_req_a, mem_is_fetch_a, issue_en_a, exec_en_a, pc_update_en_a, retire_a, halted_a, fault_a;
  logic        mem_req_b, mem_is_fetch_b, issue_en_b, exec_en_b, pc_update_en_b, retire_b, halted_b, fault_b;
  logic [31:0] instret_a, stall_a, instret_b, stall_b;

  cpu_stage_sequencer #(.SKIP_MEM(1'b0), .MAX_WAIT(4)) dut_a (
    .clk(clk), .rst(rst_a), .run_en(run_en), .instr_type(instr_type),
    .instr_is_mem(instr_is_mem), .mem_ready(mem_ready), .stage(stage_a),
    .mem_req(mem_req_a), .mem_is_fetch(mem_is_fetch_a), .issue_en(issue_en_a),
    .exec_en(exec_en_a), .pc_update_en(pc_update_en_a), .retire(retire_a),
    .halted(halted_a), .fault(fault_a), .instret(instret_a), .stall_cycles(stall_a)
  );

  cpu_stage_sequencer #(.SKIP_MEM(1'b1), .MAX_WAIT(4)) dut_b (
    .clk(clk), .rst(rst_b), .run_en(run_en), .instr_type(instr_type),
    .instr_is_mem(instr_is_mem), .mem_ready(mem_ready), .stage(stage_b),
    .mem_req(mem_req_b), .mem_is_fetch(mem_is_fetch_b), .issue_en(issue_en_b),
    .exec_en(exec_en_b), .pc_update_en(pc_update_en_b), .retire(retire_b),
    .halted(halted_b), .fault(fault_b), .instret(instret_b), .stall_cycles(stall_b)
  );

  logic [10:0] ctrl_a;
  assign ctrl_a = {stage_a, mem_req_a, mem_is_fetch_a, issue_en_a, exec_en_a,
                   pc_update_en_a, retire_a, halted_a, fault_a};

  logic        mon_rst, mon_req, mon_fetch, mon_issue, mon_retire, mon_halted, mon_fault;
  logic [31:0] mon_instret;
  assign mon_rst     = sel ? rst_b : rst_a;
  assign mon_req     = sel ? mem_req_b : mem_req_a;
  assign mon_fetch   = sel ? mem_is_fetch_b : mem_is_fetch_a;
  assign mon_issue   = sel ? issue_en_b : issue_en_a;
  assign mon_retire  = sel ? retire_b : retire_a;
  assign mon_halted  = sel ? halted_b : halted_a;
  assign mon_fault   = sel ? fault_b : fault_a;
  assign mon_instret = sel ? instret_b : instret_a;

  int   n_tests = 0;
  int   n_fail  = 0;
  ev_t  exp_q[$];
  int   mon_cnt = 0;
  int   req_cnt = 0;
  int   fetch_lat, data_lat;
  int   halt_req_cnt;
  int   cur_cyc;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input int cyc, input int aux);
    ev_t e;
    e.kind = kind;
    e.cyc  = 16'(cyc);
    e.aux  = 32'(aux);
    exp_q.push_back(e);
  endtask

  task automatic observe(input logic [1:0] kind, input logic [31:0] aux);
    ev_t got, exp;
    got.kind = kind;
    got.cyc  = 16'(mon_cnt + 1);
    got.aux  = aux;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d cycle %0d aux %0d, none expected",
               kind, got.cyc, aux);
    end else begin
      exp = exp_q.pop_front();
      check($sformatf("event_k%0d_c%0d", exp.kind, exp.cyc), 64'(got), 64'(exp));
    end
  endtask

  // Cycle index since reset release: cycle N is in progress when mon_cnt == N-1.
  always @(posedge clk) mon_cnt <= mon_rst ? mon_cnt + 1 : 0;

  // Memory model: answers a request after the programmed number of wait cycles.
  always @(posedge clk) begin
    if (!mon_rst || !mon_req || mem_ready) req_cnt <= 0;
    else                                   req_cnt <= req_cnt + 1;
  end

  initial begin
    mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      mem_ready = mon_rst && mon_req && (req_cnt >= (mon_fetch ? fetch_lat : data_lat));
    end
  end

  // Monitor: pops the scoreboard whenever the active DUT shows an event.
  initial begin
    logic halted_prev;
    halted_prev  = 1'b0;
    halt_req_cnt = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!mon_rst) begin
        halted_prev  = 1'b0;
        halt_req_cnt = 0;
      end else begin
        if (mon_issue)  observe(EV_ISSUE, 32'd0);
        if (mon_retire) observe(EV_RETIRE, mon_instret);
        if (mon_halted && !halted_prev) observe(EV_HALT, {31'd0, mon_fault});
        if (mon_halted && mon_req) halt_req_cnt++;
        halted_prev = mon_halted;
      end
    end
  end

  task automatic go(input int target);
    while (cur_cyc < target) begin
      @(negedge clk);
      cur_cyc++;
    end
  endtask

  task automatic start(input logic use_b);
    rst_a = 1'b0;
    rst_b = 1'b0;
    run_en = 1'b0;
    repeat (3) @(negedge clk);
    sel = use_b;
    if (use_b) rst_b = 1'b1;
    else       rst_a = 1'b1;
    cur_cyc = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    sel = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
    run_en = 1'b1; instr_type = T_ALU; instr_is_mem = 1'b0;
    fetch_lat = 0; data_lat = 0; cur_cyc = 0;

    // Reset state, with run_en already high.
    repeat (2) @(negedge clk);
    #3;
    check("reset_ctrl", 64'(ctrl_a), 64'd0);
    check("reset_instret", 64'(instret_a), 64'd0);
    check("reset_stall", 64'(stall_a), 64'd0);

    // Three ALU instructions, zero-wait memory: retire at 5, 10, 15.
    start(1'b0);
    run_en = 1'b1; instr_type = T_ALU; instr_is_mem = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(EV_ISSUE, 1 + 5 * i, 0);
      push(EV_RETIRE, 5 + 5 * i, i);
    end
    go(13); run_en = 1'b0;            // dropped in EXECUTE of the third
    go(20); #3;
    check("alu_idle_stage", 64'(stage_a), 64'(ST_FETCH));
    check("alu_idle_req", 64'(mem_req_a), 64'd0);
    check("alu_instret", 64'(instret_a), 64'd3);
    check("alu_stall", 64'(stall_a), 64'd0);

    // Fetch stalled 3 cycles; run_en dropped during the stall.
    go(21); fetch_lat = 3; run_en = 1'b1;
    push(EV_ISSUE, 24, 0);
    push(EV_RETIRE, 28, 3);
    go(22); run_en = 1'b0;
    #3;
    check("fetch_hold_req", 64'(mem_req_a), 64'd1);
    go(31); #3;
    check("fetch_stall", 64'(stall_a), 64'd3);
    check("fetch_instret", 64'(instret_a), 64'd4);
    check("fetch_idle_req", 64'(mem_req_a), 64'd0);

    // Load answered on the 4th MEMORY cycle: no fault with MAX_WAIT=4.
    go(32); fetch_lat = 0; data_lat = 3; instr_type = T_LOAD; instr_is_mem = 1'b1; run_en = 1'b1;
    push(EV_ISSUE, 32, 0);
    push(EV_RETIRE, 39, 4);
    go(34); run_en = 1'b0;
    go(42); #3;
    check("load_fault", 64'(fault_a), 64'd0);
    check("load_halted", 64'(halted_a), 64'd0);
    check("load_stall", 64'(stall_a), 64'd6);
    check("load_instret", 64'(instret_a), 64'd5);

    // Store never answered: watchdog faults after 4 wait cycles.
    go(43); data_lat = 1000; instr_type = T_STORE; run_en = 1'b1;
    push(EV_ISSUE, 43, 0);
    push(EV_HALT, 50, 1);
    go(45); run_en = 1'b0;
    go(49); #3;
    check("wd_last_wait_stage", 64'(stage_a), 64'(ST_MEMORY));
    check("wd_last_wait_fault", 64'(fault_a), 64'd0);
    go(53); #3;
    check("wd_fault", 64'(fault_a), 64'd1);
    check("wd_halted", 64'(halted_a), 64'd1);
    check("wd_stage", 64'(stage_a), 64'(ST_HALT));
    check("wd_req", 64'(mem_req_a), 64'd0);
    check("wd_stall", 64'(stall_a), 64'd10);
    check("wd_instret", 64'(instret_a), 64'd5);

    // Asynchronous reset in the middle of a MEMORY wait.
    start(1'b0);
    run_en = 1'b1; instr_type = T_LOAD; instr_is_mem = 1'b1; data_lat = 1000;
    push(EV_ISSUE, 1, 0);
    go(3); run_en = 1'b0;
    go(5); #3;
    check("mid_mem_stage", 64'(stage_a), 64'(ST_MEMORY));
    check("mid_mem_req", 64'(mem_req_a), 64'd1);
    rst_a = 1'b0;
    #1;
    check("async_rst_ctrl", 64'(ctrl_a), 64'd0);
    check("async_rst_instret", 64'(instret_a), 64'd0);
    check("async_rst_stall", 64'(stall_a), 64'd0);

    // HALT instruction: absorbing, no requests even with run_en high.
    start(1'b0);
    run_en = 1'b1; instr_type = T_HALT; instr_is_mem = 1'b0; data_lat = 0;
    push(EV_ISSUE, 1, 0);
    push(EV_HALT, 3, 0);
    go(23); #3;
    check("halt_req_cycles", 64'(halt_req_cnt), 64'd0);
    check("halt_halted", 64'(halted_a), 64'd1);
    check("halt_stage", 64'(stage_a), 64'(ST_HALT));
    check("halt_instret", 64'(instret_a), 64'd0);
    check("halt_fault", 64'(fault_a), 64'd0);

    // SKIP_MEM=1: ALU every 4 cycles, a load still takes 5.
    start(1'b1);
    run_en = 1'b1; instr_type = T_ALU; instr_is_mem = 1'b0; fetch_lat = 0; data_lat = 0;
    for (int i = 0; i < 3; i++) begin
      push(EV_ISSUE, 1 + 4 * i, 0);
      push(EV_RETIRE, 4 + 4 * i, i);
    end
    push(EV_ISSUE, 13, 0);
    push(EV_RETIRE, 17, 3);
    go(13); instr_type = T_LOAD; instr_is_mem = 1'b1;
    go(15); run_en = 1'b0;
    go(20); #3;
    check("skip_instret", 64'(instret_b), 64'd4);
    check("skip_stall", 64'(stall_b), 64'd0);
    check("skip_stage", 64'(stage_b), 64'(ST_FETCH));
    check("skip_req", 64'(mem_req_b), 64'd0);

    go(22);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
